fetch_pc_ctrl: RTL and testbench
================================

// Module: fetch_pc_ctrl
// PURPOSE
//  Fetch-stage PC sequencer for the pipelined core: owns the architectural PC register and sequences
//  instruction-memory requests (req/gnt/rvalid) and the IF->ID hand-off (valid/ready).
//  Applies trap/branch redirects and discards stale fetches in flight. Sits between the EX/trap redirect sources and the IF/ID register.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset (bits[1:0] must be 00)
//  PC_STEP   32'd4          sequential increment
// PORTS
//  clk_i            in   1   clock; all state changes on rising edge
//  rst_i            in   1   synchronous reset, active-high
//  trap_valid_i     in   1   trap/exception redirect request (highest priority)
//  trap_pc_i        in   32  trap target
//  redirect_valid_i in   1   branch/jump redirect from EX
//  redirect_pc_i    in   32  branch/jump target
//  imem_req_o       out  1   instruction fetch request
//  imem_addr_o      out  32  fetch address (= pc_q)
//  imem_gnt_i       in   1   request accepted this cycle
//  imem_rvalid_i    in   1   read data valid (earliest the cycle after gnt)
//  imem_rdata_i     in   32  instruction word
//  if_valid_o       out  1   instruction valid to IF/ID
//  if_pc_o          out  32  PC of presented instruction
//  if_instr_o       out  32  presented instruction
//  if_ready_i       in   1   IF/ID accepts (low = hazard stall)
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state=IDLE, kill_q=0, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=NOP (32'h0000_0013).
//  Redirect target = trap_pc_i if trap_valid_i, else redirect_pc_i; bits[1:0] forced to 00. Trap wins when both set.
//  Sequential next PC = pc_q + PC_STEP, 32-bit, carry dropped (32'hFFFF_FFFC -> 32'h0000_0000).
//  At most one fetch outstanding.
//  FSM states:
//   IDLE: one cycle after reset release, then REQ. Redirect here loads pc_q; still goes to REQ.
//   REQ:  imem_req_o=1, imem_addr_o=pc_q.
//         - gnt without redirect -> WAIT.
//         - redirect without gnt -> pc_q=target, stay REQ; addr changes next cycle (imem tolerates change before gnt).
//         - redirect with gnt -> pc_q=target, kill_q=1 -> WAIT.
//   WAIT: imem_req_o=0.
//         - redirect -> pc_q=target, kill_q=1.
//         - rvalid with kill_q=0 and no redirect this cycle -> capture rdata into if_instr_o, if_pc_o=pc_q, if_valid_o=1 next cycle -> HOLD.
//         - rvalid with kill_q=1, or redirect in the same cycle -> drop data, kill_q=0 -> REQ at new pc_q.
//   HOLD: if_valid_o=1; outputs stable while if_ready_i=0.
//         - if_ready_i=1, no redirect -> pc_q=pc_q+PC_STEP, if_valid_o=0 -> REQ.
//         - redirect (any if_ready_i) -> held instruction dropped, if_valid_o=0 next cycle, pc_q=target -> REQ.
//  Latency: first imem_req_o in 2nd cycle after rst_i falls.
//  Best-case issue rate is 1 instr / 3 cycles (REQ, WAIT, HOLD) with gnt in REQ cycle and rvalid the following cycle.
//  imem_rvalid_i outside WAIT is ignored (covers fetch returning after reset mid-operation).
//  rst_i mid-operation: returns to reset state next edge regardless of state; outstanding fetch forgotten.
// STRUCTURE
//  Shared package riscv_pkg holds: typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_e; INSTR_NOP=32'h0000_0013; PC_STEP default.
//  One sub-module: existing full_adder_32bit computes pc_q + PC_STEP (C_i=0, c_o unconnected). FSM, pc_q and IF output regs are local.
// TESTING
//  1 Reset release, gnt same cycle as req, rvalid next cycle, if_ready=1 -> addrs 0x0,0x4,0x8 issued; if_pc 0x0,0x4,0x8 with matching instr.
//  2 if_ready=0 for 5 cycles in HOLD at pc 0x8 -> if_valid/if_pc/if_instr stable, no imem_req_o; ready=1 -> next req addr 0xC.
//  3 redirect_pc=0x100 in WAIT, rvalid next cycle with 0xDEAD_BEEF -> word dropped, if_valid stays 0, next req addr 0x100.
//  4 trap_pc=0x80 and redirect_pc=0x200 in same cycle -> next fetch addr 0x80.
//  5 RESET_PC=32'hFFFF_FFFC, one fetch accepted -> next req addr 0x0000_0000.
//  6 rst_i pulsed in WAIT, stale rvalid arrives during IDLE/REQ -> ignored; fetch restarts at RESET_PC, if_instr=NOP during reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM state encoding, canonical NOP and
// PC arithmetic constants used by the fetch stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit adder with carry in/out; used for the sequential PC increment.
module full_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_i,
    output logic [31:0] s,
    output logic        c_o
);

    assign {c_o, s} = {1'b0, a} + {1'b0, b} + {32'b0, c_i};

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns pc_q, issues one imem fetch at a time,
// presents the result to IF/ID and discards fetches overtaken by redirects.
module fetch_pc_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        trap_valid_i,
    input  logic [31:0] trap_pc_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_seq;
    logic [31:0]  redirect_target;
    logic         redirect;
    logic         kill_q, kill_d;
    logic         valid_q, valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic         pc_carry_unused;

    full_adder_32bit u_pc_adder (
        .a   (pc_q),
        .b   (PC_STEP),
        .c_i (1'b0),
        .s   (pc_seq),
        .c_o (pc_carry_unused)
    );

    // Trap outranks a branch redirect raised in the same cycle.
    assign redirect        = trap_valid_i | redirect_valid_i;
    assign redirect_target = align_pc(trap_valid_i ? trap_pc_i : redirect_pc_i);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        imem_req_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = redirect_target;
            end
            REQ: begin
                imem_req_o = 1'b1;
                if (redirect) begin
                    pc_d = redirect_target;
                    if (imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A fetch in flight always completes; a redirect only marks its data stale.
                if (redirect) begin
                    pc_d = redirect_target;
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        valid_d    = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_i;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    state_d = REQ;
                end else if (if_ready_i) begin
                    pc_d    = pc_seq;
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= INSTR_NOP;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign if_valid_o  = valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against a PC-stream scoreboard.
module tb_fetch_pc_ctrl;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        ready = 1'b0;

    logic        req, valid;
    logic [31:0] addr, if_pc, instr;
    logic        wrap_req, wrap_valid;
    logic [31:0] wrap_addr, wrap_pc, wrap_instr;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst),
        .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(valid), .if_pc_o(if_pc), .if_instr_o(instr), .if_ready_i(ready)
    );

    // Same stimulus, PC starting at the top of the address space to exercise the wrap.
    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst),
        .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .imem_req_o(wrap_req), .imem_addr_o(wrap_addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .if_valid_o(wrap_valid), .if_pc_o(wrap_pc), .if_instr_o(wrap_instr), .if_ready_i(ready)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst, gnt, rvalid, ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr, addr2;
        logic        valid, chk_data;
        logic [31:0] pc, instr;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents: a bijection of the address, so stale data is detectable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic r, g, rv, input logic [31:0] rd, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc, e_instr);
        vec_t v;
        v.rst = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.req = e_req; v.addr = e_addr; v.addr2 = e_addr - 32'd4;
        v.valid = e_valid; v.pc = e_pc; v.instr = e_instr;
        v.chk_data = e_valid | r;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid);
        check({name, " req"}, req, e_req);
        check({name, " addr"}, addr, e_addr);
        check({name, " valid"}, valid, e_valid);
    endtask

    // Random-phase scoreboard state
    logic [31:0] exp_pc, out_addr, prev_pc, prev_instr;
    logic        busy, rv_fire, prev_valid, prev_ready, redir_last, holding;
    int          wait_cnt, presented;

    initial begin
        // Reset, three fetches with ready=1, then a five-cycle stall at 0x8.
        vecs.push_back(mk(1, 0, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0, INSTR_NOP));
        vecs.push_back(mk(1, 0, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0, INSTR_NOP));
        vecs.push_back(mk(0, 0, 0, 32'h0, 0,  1, 32'h0, 0, 32'h0, INSTR_NOP));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0,  0, 32'h0, 0, 32'h0, INSTR_NOP));
        vecs.push_back(mk(0, 0, 1, mem_word(32'h0), 1,  0, 32'h0, 1, 32'h0, mem_word(32'h0)));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1,  1, 32'h4, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0,  0, 32'h4, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 1, mem_word(32'h4), 1,  0, 32'h4, 1, 32'h4, mem_word(32'h4)));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1,  1, 32'h8, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0, 0,  0, 32'h8, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 1, mem_word(32'h8), 0,  0, 32'h8, 1, 32'h8, mem_word(32'h8)));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0, 32'h0, 0,  0, 32'h8, 1, 32'h8, mem_word(32'h8)));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1,  1, 32'hC, 0, 32'h0, 32'h0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; gnt = vecs[i].gnt; rvalid = vecs[i].rvalid;
            rdata = vecs[i].rdata; ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d req", i), req, vecs[i].req);
            check($sformatf("vec%0d addr", i), addr, vecs[i].addr);
            check($sformatf("vec%0d wrap_addr", i), wrap_addr, vecs[i].addr2);
            check($sformatf("vec%0d valid", i), valid, vecs[i].valid);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d if_pc", i), if_pc, vecs[i].pc);
                check($sformatf("vec%0d if_instr", i), instr, vecs[i].instr);
            end
        end
        gnt = 0; rvalid = 0; ready = 0;

        // Redirect while waiting: returning word must be dropped.
        gnt = 1; step(); gnt = 0;
        check_out("t3 granted", 0, 32'hC, 0);
        redirect_valid = 1; redirect_pc = 32'h100; step(); redirect_valid = 0;
        check_out("t3 redirected", 0, 32'h100, 0);
        rvalid = 1; rdata = 32'hDEAD_BEEF; step(); rvalid = 0;
        check_out("t3 dropped", 1, 32'h100, 0);

        // Trap and branch together: trap wins; low target bits are cleared.
        trap_valid = 1; trap_pc = 32'h80; redirect_valid = 1; redirect_pc = 32'h200; step();
        trap_valid = 0;
        check_out("t4 trap wins", 1, 32'h80, 0);
        redirect_pc = 32'h207; step(); redirect_valid = 0;
        check_out("t4 aligned", 1, 32'h204, 0);
        gnt = 1; step(); gnt = 0;
        rvalid = 1; rdata = mem_word(32'h204); step(); rvalid = 0;
        check_out("t4 present", 0, 32'h204, 1);
        check("t4 if_pc", if_pc, 32'h204);
        check("t4 if_instr", instr, mem_word(32'h204));

        // Redirect in HOLD while stalled, then redirect coinciding with grant.
        redirect_valid = 1; redirect_pc = 32'h40; step(); redirect_valid = 0;
        check_out("hold redirect", 1, 32'h40, 0);
        gnt = 1; redirect_valid = 1; redirect_pc = 32'h60; step(); gnt = 0; redirect_valid = 0;
        check_out("gnt redirect", 0, 32'h60, 0);
        rvalid = 1; rdata = mem_word(32'h40); step(); rvalid = 0;
        check_out("gnt redirect drop", 1, 32'h60, 0);

        // Reset mid-fetch; stale rvalid during IDLE and REQ must be ignored.
        gnt = 1; step(); gnt = 0;
        rst = 1; step();
        check_out("t6 reset", 0, 32'h0, 0);
        check("t6 reset if_pc", if_pc, 32'h0);
        check("t6 reset if_instr", instr, INSTR_NOP);
        rst = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; step();
        check_out("t6 stale idle", 1, 32'h0, 0);
        step(); rvalid = 0;
        check_out("t6 stale req", 1, 32'h0, 0);
        gnt = 1; step(); gnt = 0;
        rvalid = 1; rdata = mem_word(32'h0); step(); rvalid = 0;
        check_out("t6 restart", 0, 32'h0, 1);
        check("t6 restart instr", instr, mem_word(32'h0));

        // Random traffic checked against the architectural PC stream.
        rst = 1; step(); step(); rst = 0;
        exp_pc = 32'h0; busy = 0; rv_fire = 0; wait_cnt = 0; presented = 0;
        prev_valid = 0; prev_ready = 0; redir_last = 0; prev_pc = 0; prev_instr = 0; out_addr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (rv_fire) busy = 1'b0;

            holding = prev_valid && !prev_ready && !redir_last;
            if (holding) begin
                check("rnd hold valid", valid, 1);
                check("rnd hold if_pc", if_pc, prev_pc);
                check("rnd hold if_instr", instr, prev_instr);
                check("rnd hold no req", req, 0);
            end else if (prev_valid || redir_last) begin
                check("rnd valid drop", valid, 0);
            end else if (valid) begin
                presented++;
                check("rnd if_pc", if_pc, exp_pc);
                check("rnd if_instr", instr, mem_word(exp_pc));
            end
            if (req) begin
                check("rnd one outstanding", busy, 0);
                check("rnd req addr", addr, exp_pc);
            end

            ready          = ($urandom_range(0, 3) != 0);
            trap_valid     = ($urandom_range(0, 19) == 0);
            trap_pc        = $urandom;
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            rv_fire = 0; rvalid = 0; rdata = $urandom;
            if (busy) begin
                if (wait_cnt == 0) begin
                    rvalid = 1; rdata = mem_word(out_addr); rv_fire = 1;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                rvalid = 1;
            end
            gnt = 0;
            if (req && !busy && $urandom_range(0, 1) == 1) begin
                gnt = 1; busy = 1; out_addr = addr; wait_cnt = $urandom_range(0, 2);
            end

            prev_valid = valid; prev_ready = ready; prev_pc = if_pc; prev_instr = instr;
            redir_last = trap_valid | redirect_valid;
            if (trap_valid)          exp_pc = trap_pc & 32'hFFFF_FFFC;
            else if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (valid && ready) exp_pc = exp_pc + 32'd4;
        end
        check("rnd progress", 32'(presented >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
